// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I architectural register file at the write-back end of the pipeline.
// Latency: reads are combinational, with write-first bypass of the W-stage write; writes land in storage one cycle later.
// Backpressure: none, so the block never stalls. It also holds a0 for display and a retired-instruction counter.
module reg_file_wb #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr1_d_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr2_d_i,
  output logic [WIDTH-1:0]      rd_data1_d_o,
  output logic [WIDTH-1:0]      rd_data2_d_o,
  input  logic                  reg_wr_en_w_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_w_i,
  input  logic [WIDTH-1:0]      wr_data_w_i,
  input  logic                  retire_valid_w_i,
  output logic [WIDTH-1:0]      a0_o,
  output logic [CNT_WIDTH-1:0]  instret_o
);

  localparam int NREGS  = 2 ** ADDR_WIDTH;
  localparam int A0_IDX = 10;

  // Entry 0 exists but is never written, so it stays at zero from reset onward.
  logic [WIDTH-1:0]     regs [NREGS];
  logic [CNT_WIDTH-1:0] instret_q;

  // A write to x0 is dropped here, so storage needs no special handling for x0.
  logic wr_fire;
  assign wr_fire = reg_wr_en_w_i && (wr_addr_w_i != '0);

  // Storage update: reset clears every entry immediately, with no clock required.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wr_addr_w_i] <= wr_data_w_i;
    end
  end

  // Retired-instruction count. Only the W valid bit qualifies it, so stores and branches count too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else if (retire_valid_w_i) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Read port 1 is write-first. Bypass is blocked during reset so that reads return the cleared storage.
  always_comb begin
    rd_data1_d_o = '0;
    if (rd_addr1_d_i != '0) begin
      if (!rst_i && wr_fire && (wr_addr_w_i == rd_addr1_d_i)) begin
        rd_data1_d_o = wr_data_w_i;
      end else begin
        rd_data1_d_o = regs[rd_addr1_d_i];
      end
    end
  end

  // Read port 2 follows the same rules as port 1, independently of it.
  always_comb begin
    rd_data2_d_o = '0;
    if (rd_addr2_d_i != '0) begin
      if (!rst_i && wr_fire && (wr_addr_w_i == rd_addr2_d_i)) begin
        rd_data2_d_o = wr_data_w_i;
      end else begin
        rd_data2_d_o = regs[rd_addr2_d_i];
      end
    end
  end

  // a0 shows the stored value only, so the display changes on the edge after a write to x10.
  assign a0_o      = regs[A0_IDX];
  assign instret_o = instret_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Testbench for reg_file_wb: directed vectors, literal expectations and a per-cycle model comparison.
// A second instance built with CNT_WIDTH=4 exercises the counter wrap.
// The block has no flow control, so the bench drives inputs freely every cycle.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic        wen = 1'b0, ret = 1'b0;
  logic [31:0] wd = '0;

  logic [31:0] rd1, rd2, a0;
  logic [63:0] instret;
  logic [31:0] rd1_n, rd2_n, a0_n;
  logic [3:0]  instret_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk_i(clk), .rst_i(rst),
    .rd_addr1_d_i(ra1), .rd_addr2_d_i(ra2),
    .rd_data1_d_o(rd1), .rd_data2_d_o(rd2),
    .reg_wr_en_w_i(wen), .wr_addr_w_i(wa), .wr_data_w_i(wd),
    .retire_valid_w_i(ret), .a0_o(a0), .instret_o(instret)
  );

  reg_file_wb #(.CNT_WIDTH(4)) dut_n (
    .clk_i(clk), .rst_i(rst),
    .rd_addr1_d_i(ra1), .rd_addr2_d_i(ra2),
    .rd_data1_d_o(rd1_n), .rd_data2_d_o(rd2_n),
    .reg_wr_en_w_i(wen), .wr_addr_w_i(wa), .wr_data_w_i(wd),
    .retire_valid_w_i(ret), .a0_o(a0_n), .instret_o(instret_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural model: an array of register values plus plain integer counters.
  logic [31:0] m_regs [32] = '{default: 32'h0};
  logic [63:0] m_cnt  = '0;
  logic [3:0]  m_cnt4 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_cnt  = '0;
      m_cnt4 = '0;
    end else begin
      if (wen && wa != 5'd0) m_regs[wa] = wd;
      if (ret) begin
        m_cnt  = m_cnt + 64'd1;
        m_cnt4 = m_cnt4 + 4'd1;
      end
    end
  end

  // Expected read value: x0 reads as zero, a same-cycle W write wins, otherwise the stored value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && wen && wa == a) return wd;
    return m_regs[a];
  endfunction

  // Check every output against the model on each falling edge.
  always @(negedge clk) begin
    check("cmp_rd1", {32'h0, rd1}, {32'h0, exp_rd(ra1)});
    check("cmp_rd2", {32'h0, rd2}, {32'h0, exp_rd(ra2)});
    check("cmp_a0", {32'h0, a0}, {32'h0, m_regs[10]});
    check("cmp_instret", instret, m_cnt);
    check("cmp_instret4", {60'h0, instret_n}, {60'h0, m_cnt4});
  end

  task automatic cyc(input logic e, input logic [4:0] a, input logic [31:0] d,
                     input logic r, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #1;
    wen = e; wa = a; wd = d; ret = r; ra1 = r1; ra2 = r2;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_instret", instret, 64'd0);
    check("rst_a0", {32'h0, a0}, 64'd0);

    // Write x5, then apply an asynchronous reset in the middle of a cycle
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0);
    check("x5_bypass", {32'h0, rd1}, 64'hDEADBEEF);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
    check("x5_stored", {32'h0, rd1}, 64'hDEADBEEF);
    check("instret_one", instret, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_x5", {32'h0, rd1}, 64'd0);
    check("midrst_a0", {32'h0, a0}, 64'd0);
    check("midrst_instret", instret, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("postrst_x5", {32'h0, rd1}, 64'd0);

    // Basic write and read on both ports
    cyc(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
    check("x3_port1", {32'h0, rd1}, 64'h12345678);
    check("x3_port2", {32'h0, rd2}, 64'h12345678);
    #1 ra1 = 5'd4;
    #1;
    check("x4_zero", {32'h0, rd1}, 64'd0);

    // A write to x0 is discarded and never bypassed
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    check("x0_same", {32'h0, rd1}, 64'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    check("x0_later", {32'h0, rd1}, 64'd0);

    // Bypass on both ports; a0 only changes after the edge
    cyc(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 5'd7, 32'hAA, 1'b0, 5'd7, 5'd7);
    check("byp_port1", {32'h0, rd1}, 64'hAA);
    check("byp_port2", {32'h0, rd2}, 64'hAA);
    check("byp_a0", {32'h0, a0}, 64'd0);
    cyc(1'b1, 5'd10, 32'h55, 1'b0, 5'd10, 5'd0);
    check("a0_before", {32'h0, a0}, 64'd0);
    check("a0_rd_byp", {32'h0, rd1}, 64'h55);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 5'd0);
    check("a0_after", {32'h0, a0}, 64'h55);

    // Counter follows the retire pattern 1,1,0,1
    do_reset();
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    check("cnt_a", instret, 64'd1);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    check("cnt_b", instret, 64'd2);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    check("cnt_c", instret, 64'd2);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    check("cnt_d", instret, 64'd3);

    // The 4-bit counter wraps from all-ones to zero
    do_reset();
    repeat (15) cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    check("wrap_full", {60'h0, instret_n}, 64'd15);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    check("wrap_zero", {60'h0, instret_n}, 64'd0);
    check("wide_sixteen", instret, 64'd16);

    // A bubble write still updates the register but does not count
    cyc(1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd0);
    check("bubble_x9", {32'h0, rd1}, 64'h9);
    check("bubble_cnt", instret, 64'd16);

    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
